// File: rtl/classifier_pkg.sv
// Shared widths, descriptor layout and FSM encoding for the cascade stage evaluator.
// Widths derive from the integral-image word width and the descriptor field widths.
// The descriptor struct mirrors the fields latched when a feature is accepted.
package classifier_pkg;

  localparam int W_DATA   = 18;
  localparam int W_WEIGHT = 3;
  localparam int W_THR    = 16;
  localparam int W_VN     = 16;
  localparam int W_LEAF   = 14;

  // Signed rect sum, feature sum with headroom for three weighted rects,
  // and full threshold * normalisation product (vnorm is unsigned, hence +1).
  localparam int W_SUM  = W_DATA + 1;
  localparam int W_FSUM = W_SUM + W_WEIGHT + 2;
  localparam int W_PROD = W_THR + W_VN + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_CMP  = 2'd2,
    ST_DEC  = 2'd3
  } eval_state_t;

  typedef struct packed {
    logic [1:0]                rcnt;
    logic signed [W_WEIGHT-1:0] w0;
    logic signed [W_WEIGHT-1:0] w1;
    logic signed [W_WEIGHT-1:0] w2;
    logic signed [W_THR-1:0]    thr;
    logic signed [W_LEAF-1:0]   left;
    logic signed [W_LEAF-1:0]   right;
    logic                       stage_last;
  } feature_desc_t;

  // A descriptor advertising zero rectangles still consumes one rect sum.
  function automatic logic [1:0] eff_rcnt(input logic [1:0] rcnt);
    return (rcnt == 2'd0) ? 2'd1 : rcnt;
  endfunction

endpackage

// File: rtl/rect_mac.sv
// Signed weight x rect-sum multiply-accumulate for one Haar feature.
// One-cycle update: acc reflects a sample the cycle after en is high.
// No flow control of its own; the caller gates en with the rect-sum handshake.
module rect_mac #(
  parameter int W_IN  = classifier_pkg::W_SUM,
  parameter int W_W   = classifier_pkg::W_WEIGHT,
  parameter int W_ACC = classifier_pkg::W_FSUM
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [W_W-1:0]   weight,
  input  logic signed [W_IN-1:0]  sample,
  output logic signed [W_ACC-1:0] acc
);

  localparam int W_MUL = W_IN + W_W;

  // Full-precision signed product; both operands widened before multiplying.
  logic signed [W_MUL-1:0] prod;
  assign prod = W_MUL'(weight) * W_MUL'(sample);

  // Accumulate sign-extended products; clear starts a new feature.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + W_ACC'(prod);
    end
  end

endmodule

// File: rtl/stage_evaluator.sv
// Evaluates Haar features against normalised thresholds and accumulates leaves per stage.
// Feature: 1 descriptor cycle + k rect cycles + 1 compare cycle; decision 2 cycles after last rect.
// Only one of feat_ready / rsum_ready / dec_valid is high at a time; dec_valid holds until dec_ready.
module stage_evaluator #(
  parameter int W_DATA   = 18,
  parameter int W_WEIGHT = 3,
  parameter int W_THR    = 16,
  parameter int W_VN     = 16,
  parameter int W_LEAF   = 14,
  parameter int W_STAGE  = 22
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rsum_valid,
  output logic                      rsum_ready,
  input  logic signed [W_DATA:0]    rsum_data,
  input  logic                      feat_valid,
  output logic                      feat_ready,
  input  logic [1:0]                feat_rcnt,
  input  logic signed [W_WEIGHT-1:0] feat_w0,
  input  logic signed [W_WEIGHT-1:0] feat_w1,
  input  logic signed [W_WEIGHT-1:0] feat_w2,
  input  logic signed [W_THR-1:0]   feat_thr,
  input  logic signed [W_LEAF-1:0]  feat_left,
  input  logic signed [W_LEAF-1:0]  feat_right,
  input  logic                      feat_stage_last,
  input  logic signed [W_STAGE-1:0] feat_stage_thr,
  input  logic [W_VN-1:0]           vnorm,
  output logic                      dec_valid,
  input  logic                      dec_ready,
  output logic                      dec_pass
);

  import classifier_pkg::*;

  // Common width for the feature-sum vs scaled-threshold compare.
  localparam int W_CMP = (W_FSUM > W_PROD) ? W_FSUM : W_PROD;

  eval_state_t state_q, state_d;

  feature_desc_t             desc_q;
  logic signed [W_STAGE-1:0] stage_thr_q;
  logic signed [W_STAGE-1:0] stage_acc_q;
  logic [1:0]                idx_q;
  logic                      pass_q;

  logic                      feat_hs;
  logic                      rsum_hs;
  logic                      dec_hs;
  logic                      last_rect;
  logic signed [W_WEIGHT-1:0] cur_w;
  logic signed [W_FSUM-1:0]  fsum;
  logic signed [W_PROD-1:0]  thr_scaled;
  logic                      fsum_lt;
  logic signed [W_LEAF-1:0]  leaf;
  logic signed [W_STAGE-1:0] stage_sum;

  assign feat_hs = feat_valid && feat_ready;
  assign rsum_hs = rsum_valid && rsum_ready;
  assign dec_hs  = dec_valid && dec_ready;

  // The rect index points at the weight for the next rect sum expected.
  assign last_rect = (idx_q == (eff_rcnt(desc_q.rcnt) - 2'd1));

  // Weight for the rect currently being accepted.
  always_comb begin
    cur_w = desc_q.w2;
    case (idx_q)
      2'd0:    cur_w = desc_q.w0;
      2'd1:    cur_w = desc_q.w1;
      default: cur_w = desc_q.w2;
    endcase
  end

  rect_mac #(
    .W_IN  (W_SUM),
    .W_W   (W_WEIGHT),
    .W_ACC (W_FSUM)
  ) u_rect_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (feat_hs),
    .en     (rsum_hs),
    .weight (cur_w),
    .sample (rsum_data),
    .acc    (fsum)
  );

  // vnorm is unsigned: a zero bit on top keeps it positive in the signed product.
  assign thr_scaled = W_PROD'($signed(desc_q.thr)) * W_PROD'($signed({1'b0, vnorm}));
  assign fsum_lt    = W_CMP'(fsum) < W_CMP'(thr_scaled);
  assign leaf       = fsum_lt ? $signed(desc_q.left) : $signed(desc_q.right);
  // Stage accumulator wraps at its own width; overflow is silently ignored.
  assign stage_sum  = stage_acc_q + W_STAGE'(leaf);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs; each state owns exactly one handshake.
  always_comb begin
    state_d    = state_q;
    feat_ready = 1'b0;
    rsum_ready = 1'b0;
    dec_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        feat_ready = 1'b1;
        if (feat_valid) state_d = ST_ACC;
      end
      ST_ACC: begin
        rsum_ready = 1'b1;
        if (rsum_valid && last_rect) state_d = ST_CMP;
      end
      ST_CMP: begin
        state_d = desc_q.stage_last ? ST_DEC : ST_IDLE;
      end
      ST_DEC: begin
        dec_valid = 1'b1;
        if (dec_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Descriptor latch, rect index, stage accumulation and decision register.
  always_ff @(posedge clk) begin
    if (rst) begin
      desc_q      <= '0;
      stage_thr_q <= '0;
      idx_q       <= '0;
      stage_acc_q <= '0;
      pass_q      <= 1'b0;
    end else begin
      if (feat_hs) begin
        desc_q.rcnt       <= feat_rcnt;
        desc_q.w0         <= feat_w0;
        desc_q.w1         <= feat_w1;
        desc_q.w2         <= feat_w2;
        desc_q.thr        <= feat_thr;
        desc_q.left       <= feat_left;
        desc_q.right      <= feat_right;
        desc_q.stage_last <= feat_stage_last;
        idx_q             <= '0;
        if (feat_stage_last) stage_thr_q <= feat_stage_thr;
      end
      if (rsum_hs) begin
        idx_q <= idx_q + 2'd1;
      end
      if (state_q == ST_CMP) begin
        stage_acc_q <= stage_sum;
        if (desc_q.stage_last) pass_q <= (stage_sum >= stage_thr_q);
      end
      if (dec_hs) begin
        stage_acc_q <= '0;
      end
    end
  end

  assign dec_pass = pass_q;

endmodule

// File: tb/tb_stage_evaluator.sv
// Self-checking bench for stage_evaluator: directed scenarios plus randomized stages.
// Expected decisions come from an arithmetic model of the feature/stage rules.
// Handshakes are driven on the falling edge and observed on the falling edge.
module tb_stage_evaluator;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               rsum_valid, rsum_ready;
  logic signed [18:0] rsum_data;
  logic               feat_valid, feat_ready;
  logic [1:0]         feat_rcnt;
  logic signed [2:0]  feat_w0, feat_w1, feat_w2;
  logic signed [15:0] feat_thr;
  logic signed [13:0] feat_left, feat_right;
  logic               feat_stage_last;
  logic signed [21:0] feat_stage_thr;
  logic [15:0]        vnorm;
  logic               dec_valid, dec_ready, dec_pass;

  int checks = 0;
  int failures = 0;

  // Feature table for the stage being played.
  int f_rcnt[8];
  int f_w[8][3];
  int f_rs[8][3];
  int f_thr[8];
  int f_l[8];
  int f_r[8];
  bit f_last[8];
  int s_thr;
  int s_vn;

  always #5 clk = ~clk;

  stage_evaluator dut (
    .clk(clk), .rst(rst),
    .rsum_valid(rsum_valid), .rsum_ready(rsum_ready), .rsum_data(rsum_data),
    .feat_valid(feat_valid), .feat_ready(feat_ready), .feat_rcnt(feat_rcnt),
    .feat_w0(feat_w0), .feat_w1(feat_w1), .feat_w2(feat_w2), .feat_thr(feat_thr),
    .feat_left(feat_left), .feat_right(feat_right), .feat_stage_last(feat_stage_last),
    .feat_stage_thr(feat_stage_thr), .vnorm(vnorm),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_pass(dec_pass)
  );

  // ---------------- reference model ----------------
  function automatic longint wrap_stage(input longint v);
    longint m;
    m = v & ((longint'(1) << 22) - 1);
    if (m >= (longint'(1) << 21)) m = m - (longint'(1) << 22);
    return m;
  endfunction

  function automatic bit model_pass(input int nf);
    longint acc, fs, prod;
    int k, leaf;
    acc = 0;
    for (int i = 0; i < nf; i++) begin
      k = (f_rcnt[i] == 0) ? 1 : f_rcnt[i];
      fs = 0;
      for (int j = 0; j < k; j++) fs += longint'(f_w[i][j]) * longint'(f_rs[i][j]);
      prod = longint'(f_thr[i]) * longint'(s_vn);
      leaf = (fs < prod) ? f_l[i] : f_r[i];
      acc = wrap_stage(acc + longint'(leaf));
    end
    return (acc >= longint'(s_thr));
  endfunction

  // ---------------- drivers (observe only, no judging) ----------------
  task automatic set_feat(input int i, input int rc, input int w0, input int w1, input int w2,
                          input int r0, input int r1, input int r2, input int thr,
                          input int l, input int r, input bit last);
    f_rcnt[i] = rc;
    f_w[i][0] = w0; f_w[i][1] = w1; f_w[i][2] = w2;
    f_rs[i][0] = r0; f_rs[i][1] = r1; f_rs[i][2] = r2;
    f_thr[i] = thr; f_l[i] = l; f_r[i] = r; f_last[i] = last;
  endtask

  // Plays descriptor i and its rect sums. Returns with the bench at the falling
  // edge two cycles after the last rect handshake; obs1/obs2 capture
  // {rsum_ready, feat_ready, dec_valid} one and two cycles after it.
  task automatic play_feature(input int i, input int gapmax, input bit early, output bit ok,
                              output logic [2:0] obs1, output logic [2:0] obs2);
    int n, k;
    ok = 1'b1;
    k = (f_rcnt[i] == 0) ? 1 : f_rcnt[i];
    feat_valid = 1'b1;
    feat_rcnt = 2'(f_rcnt[i]);
    feat_w0 = 3'(f_w[i][0]); feat_w1 = 3'(f_w[i][1]); feat_w2 = 3'(f_w[i][2]);
    feat_thr = 16'(f_thr[i]);
    feat_left = 14'(f_l[i]); feat_right = 14'(f_r[i]);
    feat_stage_last = f_last[i];
    feat_stage_thr = 22'(s_thr);
    if (early) begin
      rsum_valid = 1'b1;
      rsum_data = 19'(f_rs[i][0]);
    end
    n = 0;
    while (!feat_ready && n < 100) begin @(negedge clk); n++; end
    if (feat_ready !== 1'b1 || rsum_ready !== 1'b0) ok = 1'b0;
    @(posedge clk); @(negedge clk);
    feat_valid = 1'b0;
    for (int j = 0; j < k; j++) begin
      if (!(early && j == 0)) begin
        rsum_valid = 1'b0;
        repeat ($urandom_range(0, gapmax)) @(negedge clk);
      end
      rsum_valid = 1'b1;
      rsum_data = 19'(f_rs[i][j]);
      n = 0;
      while (!rsum_ready && n < 100) begin @(negedge clk); n++; end
      if (rsum_ready !== 1'b1) ok = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    rsum_valid = 1'b0;
    obs1 = {rsum_ready, feat_ready, dec_valid};
    @(negedge clk);
    obs2 = {rsum_ready, feat_ready, dec_valid};
  endtask

  // Holds dec_ready low for 'hold' cycles, then completes the decision handshake.
  task automatic release_dec(input int hold, output bit stable, output logic [1:0] after);
    logic p0;
    stable = 1'b1;
    p0 = dec_pass;
    repeat (hold) begin
      @(negedge clk);
      if (dec_valid !== 1'b1 || dec_pass !== p0 || feat_ready !== 1'b0 || rsum_ready !== 1'b0)
        stable = 1'b0;
    end
    dec_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    dec_ready = 1'b0;
    after = {feat_ready, dec_valid};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (feat_ready !== 1'b1) begin failures++; $display("FAIL reset_feat_ready got=%b exp=1", feat_ready); end
    checks++; if (rsum_ready !== 1'b0) begin failures++; $display("FAIL reset_rsum_ready got=%b exp=0", rsum_ready); end
    checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL reset_dec_valid got=%b exp=0", dec_valid); end
    checks++; if (dec_pass !== 1'b0) begin failures++; $display("FAIL reset_dec_pass got=%b exp=0", dec_pass); end
  endtask

  // One-feature stage with the given threshold; exercises decision latency.
  task automatic test_single(input string name, input int thr);
    bit ok, st; logic [2:0] o1, o2; logic [1:0] af; bit exp;
    s_vn = 1; vnorm = 16'(s_vn); s_thr = 5;
    set_feat(0, 2, -1, 2, 0, 100, 80, 0, thr, -5, 7, 1'b1);
    exp = model_pass(1);
    play_feature(0, 0, 1'b0, ok, o1, o2);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL %s_handshake got=%b exp=1", name, ok); end
    checks++; if (o1 !== 3'b000) begin failures++; $display("FAIL %s_cmp_cycle got=%b exp=000", name, o1); end
    checks++; if (o2 !== 3'b001) begin failures++; $display("FAIL %s_dec_cycle got=%b exp=001", name, o2); end
    checks++; if (dec_pass !== exp) begin failures++; $display("FAIL %s_pass got=%b exp=%b", name, dec_pass, exp); end
    release_dec(0, st, af);
    checks++; if (af !== 2'b10) begin failures++; $display("FAIL %s_after_dec got=%b exp=10", name, af); end
  endtask

  task automatic test_multi_feature();
    bit ok, st; logic [2:0] o1, o2; logic [1:0] af; bit exp;
    s_vn = 1; vnorm = 16'(s_vn); s_thr = 12;
    for (int i = 0; i < 3; i++) set_feat(i, 3, -1, -1, 3, 10, 10, 10, 20, 4, -4, i == 2);
    exp = model_pass(3);
    for (int i = 0; i < 3; i++) begin
      play_feature(i, 1, 1'b0, ok, o1, o2);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL multi_handshake f=%0d got=%b exp=1", i, ok); end
      checks++; if (o2 !== ((i == 2) ? 3'b001 : 3'b010)) begin failures++; $display("FAIL multi_next f=%0d got=%b", i, o2); end
    end
    checks++; if (dec_pass !== exp) begin failures++; $display("FAIL multi_pass got=%b exp=%b", dec_pass, exp); end
    release_dec(0, st, af);
    // Second stage: one feature alone; a stale accumulator would flip the result.
    s_thr = 5;
    set_feat(0, 3, -1, -1, 3, 10, 10, 10, 20, 4, -4, 1'b1);
    exp = model_pass(1);
    play_feature(0, 0, 1'b0, ok, o1, o2);
    checks++; if (dec_pass !== exp) begin failures++; $display("FAIL multi_cleared got=%b exp=%b", dec_pass, exp); end
    release_dec(0, st, af);
  endtask

  task automatic test_dec_stall();
    bit ok, st; logic [2:0] o1, o2; logic [1:0] af; bit exp;
    s_vn = 3; vnorm = 16'(s_vn); s_thr = 100;
    set_feat(0, 1, 2, 0, 0, 500, 0, 0, 10, -50, 300, 1'b1);
    exp = model_pass(1);
    play_feature(0, 0, 1'b1, ok, o1, o2);
    checks++; if (dec_pass !== exp) begin failures++; $display("FAIL stall_pass got=%b exp=%b", dec_pass, exp); end
    release_dec(5, st, af);
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL stall_stable got=%b exp=1", st); end
    checks++; if (af !== 2'b10) begin failures++; $display("FAIL stall_after got=%b exp=10", af); end
  endtask

  task automatic test_reset_mid();
    bit ok, st; logic [2:0] o1, o2; logic [1:0] af; bit exp;
    s_vn = 1; vnorm = 16'(s_vn); s_thr = 100;
    // A non-last feature leaving a large leaf in the stage accumulator.
    set_feat(0, 1, 1, 0, 0, 0, 0, 0, 5, 1000, -1000, 1'b0);
    play_feature(0, 0, 1'b0, ok, o1, o2);
    // Partial feature: descriptor plus one of two rect sums, then reset.
    feat_valid = 1'b1; feat_rcnt = 2'd2; feat_w0 = 3'sd1; feat_w1 = 3'sd1; feat_w2 = 3'sd0;
    feat_thr = 16'sd0; feat_left = 14'sd1; feat_right = 14'sd1; feat_stage_last = 1'b1;
    @(posedge clk); @(negedge clk);
    feat_valid = 1'b0; rsum_valid = 1'b1; rsum_data = 19'sd7;
    @(posedge clk); @(negedge clk);
    rsum_valid = 1'b0; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    checks++; if ({feat_ready, rsum_ready, dec_valid, dec_pass} !== 4'b1000)
      begin failures++; $display("FAIL rst_mid_idle got=%b exp=1000", {feat_ready, rsum_ready, dec_valid, dec_pass}); end
    // Fresh stage: leaf 7 vs threshold 100 with an empty accumulator.
    set_feat(0, 2, 1, 1, 0, 3, 4, 0, 0, -7, 7, 1'b1);
    exp = model_pass(1);
    play_feature(0, 0, 1'b0, ok, o1, o2);
    checks++; if (o2 !== 3'b001) begin failures++; $display("FAIL rst_mid_dec got=%b exp=001", o2); end
    checks++; if (dec_pass !== exp) begin failures++; $display("FAIL rst_mid_pass got=%b exp=%b", dec_pass, exp); end
    release_dec(0, st, af);
  endtask

  task automatic test_extreme();
    bit ok, st; logic [2:0] o1, o2; logic [1:0] af; bit exp;
    s_vn = 65535; vnorm = 16'(s_vn); s_thr = 0;
    for (int t = 0; t < 2; t++) begin
      set_feat(0, 3, 3, 3, 2, -262144, -262144, -262144, (t == 0) ? -32768 : 32767, -100, 100, 1'b1);
      exp = model_pass(1);
      play_feature(0, 0, 1'b0, ok, o1, o2);
      checks++; if (dec_pass !== exp) begin failures++; $display("FAIL extreme_%0d got=%b exp=%b", t, dec_pass, exp); end
      release_dec(0, st, af);
    end
  endtask

  task automatic test_rcnt0();
    bit ok, st; logic [2:0] o1, o2; logic [1:0] af; bit exp;
    s_vn = 1; vnorm = 16'(s_vn); s_thr = 3;
    set_feat(0, 0, 2, 3, 3, 50, 9, 9, 0, -3, 3, 1'b1);
    exp = model_pass(1);
    play_feature(0, 0, 1'b0, ok, o1, o2);
    checks++; if (o1 !== 3'b000) begin failures++; $display("FAIL rcnt0_one_rsum got=%b exp=000", o1); end
    checks++; if (dec_pass !== exp) begin failures++; $display("FAIL rcnt0_pass got=%b exp=%b", dec_pass, exp); end
    release_dec(0, st, af);
  endtask

  task automatic test_random();
    bit ok, st; logic [2:0] o1, o2; logic [1:0] af; bit exp; int nf;
    for (int s = 0; s < 25; s++) begin
      nf = int'($urandom_range(1, 4));
      s_vn = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 63));
      vnorm = 16'(s_vn);
      s_thr = int'($urandom_range(0, 40000)) - 20000;
      for (int i = 0; i < nf; i++)
        set_feat(i, int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7)) - 4, int'($urandom_range(0, 7)) - 4, int'($urandom_range(0, 7)) - 4,
                 int'($urandom_range(0, 524287)) - 262144, int'($urandom_range(0, 524287)) - 262144,
                 int'($urandom_range(0, 524287)) - 262144,
                 int'($urandom_range(0, 65535)) - 32768,
                 int'($urandom_range(0, 16383)) - 8192, int'($urandom_range(0, 16383)) - 8192, i == nf - 1);
      exp = model_pass(nf);
      for (int i = 0; i < nf; i++) begin
        play_feature(i, 2, $urandom_range(0, 1) == 1, ok, o1, o2);
        checks++; if (ok !== 1'b1 || o1 !== 3'b000)
          begin failures++; $display("FAIL rand_feat s=%0d f=%0d ok=%b cmp=%b exp=1/000", s, i, ok, o1); end
        checks++; if (o2 !== ((i == nf - 1) ? 3'b001 : 3'b010))
          begin failures++; $display("FAIL rand_next s=%0d f=%0d got=%b", s, i, o2); end
      end
      checks++; if (dec_pass !== exp) begin failures++; $display("FAIL rand_pass s=%0d got=%b exp=%b", s, dec_pass, exp); end
      release_dec(int'($urandom_range(0, 3)), st, af);
      checks++; if (st !== 1'b1 || af !== 2'b10)
        begin failures++; $display("FAIL rand_dec s=%0d stable=%b after=%b exp=1/10", s, st, af); end
    end
  endtask

  initial begin
    rsum_valid = 1'b0; rsum_data = '0; feat_valid = 1'b0; feat_rcnt = '0;
    feat_w0 = '0; feat_w1 = '0; feat_w2 = '0; feat_thr = '0; feat_left = '0; feat_right = '0;
    feat_stage_last = 1'b0; feat_stage_thr = '0; vnorm = 16'd1; dec_ready = 1'b0;
    test_reset();
    test_single("basic_right", 50);
    test_single("basic_left", 61);
    test_multi_feature();
    test_dec_stall();
    test_reset_mid();
    test_extreme();
    test_rcnt0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #400000;
    $display("FAIL watchdog_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
